div_stall_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 25 ++
 rtl/div_stall_unit.sv | 138 +++++++++++++
 tb/tb_div_stall_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, counter width
// and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_Q_DBZ = '1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left by one dividend
// bit, trial-subtract the divisor and shift the resulting quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // rem_i < divisor_i keeps diff inside (-2^WIDTH, 2^WIDTH), so the top bit is a clean borrow.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit   = ~diff[WIDTH];

    assign rem_o = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_stall_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU that stalls the pipeline while busy.
// Optional DIV_CANCEL_EN adds a cancel port that aborts a division on an exception flush.
module div_stall_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     raw_q, raw_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic [WIDTH-1:0]     step_rem, step_quo;
    logic                 cancel_w;

`ifdef DIV_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        raw_d        = raw_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        dbz_d        = dbz_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        stall        = 1'b0;
        result_valid = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                stall = start;
                if (start && !cancel_w) begin
                    state_d   = DIV_BUSY;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvs_d     = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
                    raw_d     = dividend;
                    neg_quo_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_div & dividend[WIDTH-1];
                    dbz_d     = (divisor == '0);
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                if (cancel_w) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                        state_d     = DIV_DONE;
                        quotient_d  = dbz_q ? DIV_Q_DBZ : (neg_quo_q ? -step_quo : step_quo);
                        remainder_d = dbz_q ? raw_q     : (neg_rem_q ? -step_rem : step_rem);
                    end
                end
            end
            DIV_DONE: begin
                // The stalled instruction is still in EX this cycle, so start is not re-sampled.
                result_valid = 1'b1;
                state_d      = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            raw_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            raw_q       <= raw_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: latency, signed fixup, divide-by-zero,
// start held through DONE, async reset mid-run and (with DIV_CANCEL_EN) cancel.
module tb_div_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_stall_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_div   (signed_div),
        .dividend     (dividend),
        .divisor      (divisor),
`ifdef DIV_CANCEL_EN
        .cancel       (cancel),
`endif
        .stall        (stall),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after the rising edge that begins cycle 0; returns just after
    // the edge that begins cycle 34 with start still high.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_q,
                           input logic [31:0] exp_r);
        int v_cyc;
        int stall_cyc;
        logic stall_at_done;
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        v_cyc      = -1;
        stall_cyc  = 0;
        stall_at_done = 1'bx;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (c == 0) begin
                check({tag, " cycle0 stall"}, 32'(stall), 32'd1);
                check({tag, " cycle0 valid"}, 32'(result_valid), 32'd0);
            end
            if (stall) stall_cyc++;
            if (result_valid) begin
                v_cyc = c;
                stall_at_done = stall;
                break;
            end
        end
        check({tag, " latency"}, 32'(v_cyc), 32'd33);
        check({tag, " stall cycles"}, 32'(stall_cyc), 32'd33);
        check({tag, " stall at done"}, 32'(stall_at_done), 32'd0);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst_n      = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        cancel     = 1'b0;
        #3;
        check("reset stall", 32'(stall), 32'd0);
        check("reset valid", 32'(result_valid), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // start stays high through DONE; each following run begins in cycle 34
        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run_div("divu_1000_10", 1'b0, 32'd1000,       32'd10,         32'd100,        32'd0);
        run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_div("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        run_div("div_100_m7",   1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2);
        run_div("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);
        run_div("divu_max_10",  1'b0, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5);
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
        run_div("div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);

        start = 1'b0;
        @(negedge clk);
        check("idle stall", 32'(stall), 32'd0);
        check("idle valid", 32'(result_valid), 32'd0);

        // Async reset at cycle 10 of a running division
        next_cycle();
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int i = 0; i < 10; i++) next_cycle();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst mid stall", 32'(stall), 32'd0);
        check("rst mid valid", 32'(result_valid), 32'd0);
        check("rst mid quotient", quotient, 32'd0);
        check("rst mid remainder", remainder, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (result_valid) pulses++;
        end
        check("rst no pulse", 32'(pulses), 32'd0);

`ifdef DIV_CANCEL_EN
        next_cycle();
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
        start = 1'b0;
        next_cycle();
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd3;
        for (int i = 0; i < 5; i++) next_cycle();
        start  = 1'b0;
        cancel = 1'b1;
        @(negedge clk);
        check("cancel cycle5 stall", 32'(stall), 32'd1);
        next_cycle();
        cancel = 1'b0;
        @(negedge clk);
        check("cancel cycle6 stall", 32'(stall), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (result_valid) pulses++;
        end
        check("cancel no pulse", 32'(pulses), 32'd0);
        check("cancel quotient kept", quotient, 32'd2);
        check("cancel remainder kept", remainder, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
